// File: rtl/pulse_gen_if.sv
// pulse_gen_if: control/status bundle of the pulse train generator.
//   start_i, abort_i                 : train request / termination request
//   high_cycles_i, low_cycles_i      : phase lengths in clocks (CNT_W)
//   num_pulses_i                     : pulses per train (NUM_W)
//   pulse_o, busy_o, done_o,
//   aborted_o, rise_o, fall_o        : waveform and status strobes
// master = requester side, slave = generator side.
interface pulse_gen_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NUM_W = 8
) ();
    logic             start_i;
    logic             abort_i;
    logic [CNT_W-1:0] high_cycles_i;
    logic [CNT_W-1:0] low_cycles_i;
    logic [NUM_W-1:0] num_pulses_i;
    logic             pulse_o;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
    logic             rise_o;
    logic             fall_o;

    modport master (
        output start_i, abort_i, high_cycles_i, low_cycles_i, num_pulses_i,
        input  pulse_o, busy_o, done_o, aborted_o, rise_o, fall_o
    );

    modport slave (
        input  start_i, abort_i, high_cycles_i, low_cycles_i, num_pulses_i,
        output pulse_o, busy_o, done_o, aborted_o, rise_o, fall_o
    );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse train generator.
//   clk_i   : clock, rising edge
//   arst_ni : asynchronous active-low reset
//   io      : pulse_gen_if slave (start/abort/lengths in, waveform/strobes out)
// A start in IDLE latches the lengths and count; the train is N high phases of
// H clocks separated by low phases of L clocks, with no trailing low phase.
// All outputs come straight from flops.
module pulse_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NUM_W = 8
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    pulse_gen_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;        // cycles left in current phase, incl. this one
    logic [NUM_W-1:0] left_q;       // pulses left, incl. the current one
    logic [CNT_W-1:0] high_len_q;
    logic [CNT_W-1:0] low_len_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             rise_q;
    logic             fall_q;

    // A requested length of zero behaves as one clock.
    logic [CNT_W-1:0] high_len_c;
    logic [CNT_W-1:0] low_len_c;
    assign high_len_c = (io.high_cycles_i == '0) ? CNT_W'(1) : io.high_cycles_i;
    assign low_len_c  = (io.low_cycles_i  == '0) ? CNT_W'(1) : io.low_cycles_i;

    // FSM, counters and registered outputs.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            left_q     <= '0;
            high_len_q <= '0;
            low_len_q  <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (io.start_i) begin
                        high_len_q <= high_len_c;
                        low_len_q  <= low_len_c;
                        if (io.num_pulses_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                            cnt_q   <= high_len_c;
                            left_q  <= io.num_pulses_i;
                            pulse_q <= 1'b1;
                            rise_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (io.abort_i) begin
                        // abort wins over a completion in the same cycle
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        left_q    <= '0;
                        pulse_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        fall_q    <= 1'b1;
                    end else if (cnt_q == CNT_W'(1)) begin
                        pulse_q <= 1'b0;
                        fall_q  <= 1'b1;
                        if (left_q == NUM_W'(1)) begin
                            // last pulse: no trailing low phase
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            left_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOW;
                            cnt_q   <= low_len_q;
                            left_q  <= left_q - NUM_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (io.abort_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        left_q    <= '0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= HIGH;
                        cnt_q   <= high_len_q;
                        pulse_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io.pulse_o   = pulse_q;
    assign io.busy_o    = busy_q;
    assign io.done_o    = done_q;
    assign io.aborted_o = aborted_q;
    assign io.rise_o    = rise_q;
    assign io.fall_o    = fall_q;

endmodule
